// File: rtl/score_display_mux.sv
// Two-player BCD score display scanner: four multiplexed active-low 7-seg digits with dead time.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit while keeping its scan slot.
module score_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] score_a_bcd,
  input  logic [7:0] score_b_bcd,
  input  logic       update,
  output logic       update_ack,
  output logic [6:0] seg,
  output logic [3:0] dig_en
);

  localparam int CNT_W = ($clog2(REFRESH_DIV) > 8) ? $clog2(REFRESH_DIV) : 8;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       idx, idx_next;
  logic [7:0]       shadow_a, shadow_b, active_a, active_b;
  logic             pending;
  logic             transfer;
  logic [3:0]       nibble;
  logic [6:0]       seg_next;
  logic [3:0]       dig_en_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Outputs are computed for the upcoming state so they can be registered without extra latency.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 1'b1;
    idx_next    = idx;
    transfer    = 1'b0;
    nibble      = 4'd0;
    seg_next    = 7'h7F;
    dig_en_next = 4'hF;

    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = SHOW;
          cnt_next   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = idx + 2'd1;
          transfer   = 1'b1;
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase

    case (idx_next)
      2'd0:    nibble = active_a[3:0];
      2'd1:    nibble = active_a[7:4];
      2'd2:    nibble = active_b[3:0];
      default: nibble = active_b[7:4];
    endcase

    if (state_next == SHOW) begin
      dig_en_next = ~(4'b0001 << idx_next);
      seg_next    = decode(nibble);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_next[0] && (nibble == 4'd0)) seg_next = 7'h7F;
`else
      seg_next = seg_next;
`endif
    end
  end

  // Active scores only change on the SHOW-to-BLANK edge, so a lit digit never changes mid-slot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= 2'd0;
      pending    <= 1'b0;
      update_ack <= 1'b0;
      seg        <= 7'h7F;
      dig_en     <= 4'hF;
      shadow_a   <= 8'h00;
      shadow_b   <= 8'h00;
      active_a   <= 8'h00;
      active_b   <= 8'h00;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      seg        <= seg_next;
      dig_en     <= dig_en_next;
      update_ack <= transfer && pending;
      if (transfer && pending) begin
        active_a <= shadow_a;
        active_b <= shadow_b;
      end
      if (update) begin
        shadow_a <= score_a_bcd;
        shadow_b <= score_b_bcd;
        pending  <= 1'b1;
      end else if (transfer) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux (REFRESH_DIV=8, DEAD_CYCLES=2) against a slot-arithmetic model.
// Honours LEADING_ZERO_BLANK_EN in its model when the macro is defined.
module tb_score_display_mux;

  localparam int R = 8;
  localparam int D = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] score_a_bcd = 8'h00;
  logic [7:0] score_b_bcd = 8'h00;
  logic       update = 1'b0;
  logic       update_ack;
  logic [6:0] seg;
  logic [3:0] dig_en;

  always #5 clock = ~clock;

  score_display_mux #(.REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .score_a_bcd(score_a_bcd),
    .score_b_bcd(score_b_bcd),
    .update(update),
    .update_ack(update_ack),
    .seg(seg),
    .dig_en(dig_en)
  );

  int checks = 0;
  int passed = 0;

  // Model: k counts edges since reset release; scan position follows from plain division.
  int         k = 0;
  logic [7:0] m_sha = 8'h00, m_shb = 8'h00, m_acta = 8'h00, m_actb = 8'h00;
  bit         m_pend = 1'b0;
  logic       exp_ack = 1'b0;
  logic [6:0] exp_seg = 7'h7F;
  logic [3:0] exp_en = 4'hF;
  logic [6:0] glyph [16];

  function automatic bit is_transfer(int kk);
    return (kk >= D) && (((kk - D) % (D + R)) == R);
  endfunction

  function automatic bit at_pos(int kk, int dg, int w);
    return (kk >= D) && (((kk - D) % (D + R)) == w) && ((((kk - D) / (D + R)) % 4) == dg);
  endfunction

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s at k=%0d: observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  task automatic model_edge();
    bit         tr;
    int         d;
    logic [3:0] nib;
    logic [3:0] onehot;
    if (!reset_n) begin
      k = 0; m_sha = 0; m_shb = 0; m_acta = 0; m_actb = 0; m_pend = 0;
      exp_ack = 0; exp_seg = 7'h7F; exp_en = 4'hF;
      return;
    end
    k++;
    tr = is_transfer(k);
    exp_ack = tr && m_pend;
    if (exp_ack) begin
      m_acta = m_sha;
      m_actb = m_shb;
    end
    if (update) begin
      m_sha = score_a_bcd;
      m_shb = score_b_bcd;
      m_pend = 1'b1;
    end else if (tr) begin
      m_pend = 1'b0;
    end
    exp_seg = 7'h7F;
    exp_en = 4'hF;
    if (k >= D && ((k - D) % (D + R)) < R) begin
      d = ((k - D) / (D + R)) % 4;
      nib = (d == 0) ? m_acta[3:0] : (d == 1) ? m_acta[7:4] : (d == 2) ? m_actb[3:0] : m_actb[7:4];
      exp_seg = glyph[nib];
`ifdef LEADING_ZERO_BLANK_EN
      if ((d % 2 == 1) && nib == 4'd0) exp_seg = 7'h7F;
`endif
      onehot = 4'b0001 << d;
      exp_en = ~onehot;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_output("dig_en", {4'h0, dig_en}, {4'h0, exp_en});
    check_output("seg", {1'b0, seg}, {1'b0, exp_seg});
    check_output("update_ack", {7'h00, update_ack}, {7'h00, exp_ack});
  endtask

  task automatic apply_stimulus(input logic upd, input logic [7:0] a, input logic [7:0] b);
    update = upd;
    score_a_bcd = a;
    score_b_bcd = b;
    step();
    update = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until the next edge lands on the given digit/slot offset; an expired bound is a failure.
  task automatic advance_to(input int dg, input int w);
    int guard = 0;
    while (!at_pos(k + 1, dg, w) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      $error("[TB] FAIL advance_to: observed=timeout expected=digit%0d offset%0d", dg, w);
    end
  endtask

  task automatic advance_to_transfer();
    int guard = 0;
    while (!is_transfer(k + 1) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      $error("[TB] FAIL advance_to_transfer: observed=timeout expected=transfer edge");
    end
  endtask

  initial begin
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100; glyph[3] = 7'b0110000;
    glyph[4] = 7'b0011001; glyph[5] = 7'b0010010; glyph[6] = 7'b0000010; glyph[7] = 7'b1111000;
    glyph[8] = 7'b0000000; glyph[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) glyph[i] = 7'b0111111;

    $display("[TB] reset and idle scan");
    reset_n = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(45);

    $display("[TB] update mid-slot of digit0");
    advance_to(0, 3);
    apply_stimulus(1'b1, 8'h42, 8'h07);
    run(45);

    $display("[TB] update coincident with transfer");
    advance_to(1, 2);
    apply_stimulus(1'b1, 8'h11, 8'h00);
    advance_to_transfer();
    apply_stimulus(1'b1, 8'h33, 8'h00);
    run(25);

    $display("[TB] invalid nibbles and leading zero");
    apply_stimulus(1'b1, 8'hAF, 8'h05);
    run(45);
    apply_stimulus(1'b1, 8'h12, 8'h34);
    apply_stimulus(1'b1, 8'h98, 8'h76);
    run(45);

    $display("[TB] reset mid-slot of digit2 with pending update");
    advance_to(2, 3);
    apply_stimulus(1'b1, 8'h99, 8'h99);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run(45);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0)
        apply_stimulus(1'b1, 8'($urandom), 8'($urandom));
      else
        step();
    end
    reset_n = 1'b1;
    run(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/score_display_mux.md
SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, number of clock cycles each digit is driven per scan slot (legal 2..2^20).
REQ-002 The block SHALL have parameter DEAD_CYCLES, default 4, number of all-off anti-ghosting cycles between slots (legal 1..255).
REQ-003 The block SHALL have port clock, input, 1, the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port score_a_bcd, input, 8, player A score as {tens, ones} BCD nibbles.
REQ-006 The block SHALL have port score_b_bcd, input, 8, player B score as {tens, ones} BCD nibbles.
REQ-007 The block SHALL have port update, input, 1, one-cycle strobe capturing both score inputs.
REQ-008 The block SHALL have port update_ack, output, 1, one-cycle pulse when captured scores become visible.
REQ-009 The block SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dig_en, output, 4, active-low digit enables; digit0=A ones, 1=A tens, 2=B ones, 3=B tens.

Function
REQ-011 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-012 The FSM SHALL have two states: BLANK, where dig_en=4'hF and seg=7'h7F, and SHOW, where exactly one dig_en bit is low.
REQ-013 BLANK SHALL last exactly DEAD_CYCLES cycles and then move to SHOW for the current digit index.
REQ-014 SHOW SHALL last exactly REFRESH_DIV cycles and then move to BLANK, incrementing the digit index modulo 4 (3 wraps to 0).
REQ-015 An update strobe SHALL copy score_a_bcd/score_b_bcd into shadow registers and set a pending flag.
REQ-016 On each SHOW-to-BLANK transition with pending set, shadow SHALL be copied to the active registers, pending SHALL be cleared, and update_ack SHALL pulse high for that one cycle.
REQ-017 Displayed values SHALL never change while a digit is in SHOW.
REQ-018 If update coincides with a transfer, the transfer SHALL use the prior shadow contents, the new values SHALL enter shadow, and pending SHALL remain set for the next transfer.
REQ-019 Repeated update strobes before a transfer SHALL overwrite shadow; only the last values SHALL be shown, with one update_ack.
REQ-020 Nibble decode SHALL map 0-9 to standard active-low glyphs (0=7'b1000000, 1=7'b1111001, 8=7'b0000000).
REQ-021 Nibble decode SHALL map any nibble 10-15 to a dash (7'b0111111).
REQ-022 The slot counter SHALL be wide enough for REFRESH_DIV and SHALL reset to 0 on every state change.

Reset
REQ-023 With reset_n low at a rising edge, the block SHALL set state=BLANK, digit index=0, counter=0, pending=0, update_ack=0, dig_en=4'hF, seg=7'h7F, and shadow and active registers to 8'h00.
REQ-024 Reset asserted mid-SHOW or mid-pending SHALL abort the operation without an update_ack pulse.
REQ-025 After release, dig_en[0] SHALL first go low on the DEAD_CYCLES-th rising edge after reset_n is sampled high.

Configuration
REQ-026 With macro LEADING_ZERO_BLANK_EN defined, a tens digit whose active nibble is 0 SHALL display as blank (seg=7'h7F) while its dig_en bit still goes low for timing consistency.
REQ-027 Without LEADING_ZERO_BLANK_EN, a zero tens digit SHALL display the "0" glyph.
REQ-028 The ones digits SHALL never be blanked in either configuration.

Verification (REFRESH_DIV=8, DEAD_CYCLES=2)
REQ-029 Release reset with no update -> dig_en sequence F,E(8 cycles),F(2),D(8),F(2),B(8),F(2),7(8),F(2),E, with seg=7'b1000000 in every SHOW (macro off).
REQ-030 update with A=8'h42, B=8'h07 mid-SHOW of digit0 -> digit0 keeps old glyph to slot end, update_ack pulses on that SHOW-to-BLANK edge, and the next scan shows 2,4,7,0.
REQ-031 update coincident with the transfer cycle (first A=8'h11, then A=8'h33) -> the first transfer shows 11, the second update_ack occurs one slot later and shows 33.
REQ-032 A=8'hAF -> both A digits show dash 7'b0111111.
REQ-033 LEADING_ZERO_BLANK_EN defined, B=8'h05 -> digit3 seg=7'h7F with dig_en=4'h7, and digit2 shows "5" (7'b0010010).
REQ-034 reset_n low for 1 cycle mid-SHOW of digit2 with pending set -> outputs F/7F next edge, no update_ack, active scores 00.
